// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC FSM state type and the default
// address map used by the PC unit, NPC logic and instruction memory.
package cpu_pkg;

    // Fetch-PC control state: normal execution or inside the exception handler.
    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } pc_state_e;

    localparam int          ADDR_W    = 32;
    localparam logic [31:0] RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_4180;
    localparam logic [31:0] ADDR_LO   = 32'h0000_3000;
    localparam logic [31:0] ADDR_HI   = 32'h0000_6FFF;
    localparam int          INSTR_B   = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Bundle of PC-unit control inputs and status outputs.
//
// Signalling: there is no backpressure on this bundle. Every request input
// (br_valid_i, exc_req_i, eret_i, stall_i) is a level sampled on each rising
// clk edge and is acted on at that edge only; a request that loses the
// priority arbitration (e.g. a branch during stall) is dropped, not held.
// The driver must keep the inputs stable across the sampling edge.
interface pc_unit_if #(
    parameter int ADDR_W = 32
);
    import cpu_pkg::*;

    logic              stall_i;
    logic              br_valid_i;
    logic [ADDR_W-1:0] br_target_i;
    logic              exc_req_i;
    logic [ADDR_W-1:0] exc_pc_i;
    logic              eret_i;
    logic [ADDR_W-1:0] pc_o;
    logic [ADDR_W-1:0] epc_o;
    logic              in_handler_o;
    logic              fetch_fault_o;
    logic              dbl_fault_o;
    pc_state_e         state_dbg;

    // Side that issues stall/redirect/exception requests.
    modport master (
        output stall_i, br_valid_i, br_target_i, exc_req_i, exc_pc_i, eret_i,
        input  pc_o, epc_o, in_handler_o, fetch_fault_o, dbl_fault_o, state_dbg
    );

    // The PC unit itself.
    modport slave (
        input  stall_i, br_valid_i, br_target_i, exc_req_i, exc_pc_i, eret_i,
        output pc_o, epc_o, in_handler_o, fetch_fault_o, dbl_fault_o, state_dbg
    );

endinterface

// File: rtl/pc_range_chk.sv
// Combinational legality check of an address against an inclusive window
// and instruction alignment. A legal address must leave room for a whole
// instruction below ADDR_HI.
module pc_range_chk #(
    parameter int              ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] ADDR_LO = ADDR_W'(cpu_pkg::ADDR_LO),
    parameter logic [ADDR_W-1:0] ADDR_HI = ADDR_W'(cpu_pkg::ADDR_HI),
    parameter int              INSTR_B = cpu_pkg::INSTR_B
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              legal
);
    // INSTR_B is a power of two, so INSTR_B-1 masks the offset-in-instruction bits.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_B - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_HI - ALIGN_MASK;

    logic in_low;
    logic in_high;
    logic aligned;

    assign in_low  = (addr >= ADDR_LO);
    assign in_high = (addr <= LAST_ADDR);
    assign aligned = ((addr & ALIGN_MASK) == '0);
    assign legal   = in_low && in_high && aligned;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter. Holds PC, EPC, handler state and the sticky
// double-fault flag; picks the next PC with priority
// exception > return > stall > branch > sequential, and diverts any illegal
// candidate PC to the exception vector.
module pc_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(cpu_pkg::RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(cpu_pkg::EXC_VEC),
    parameter logic [ADDR_W-1:0] ADDR_LO   = ADDR_W'(cpu_pkg::ADDR_LO),
    parameter logic [ADDR_W-1:0] ADDR_HI   = ADDR_W'(cpu_pkg::ADDR_HI),
    parameter int                INSTR_B   = cpu_pkg::INSTR_B
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_unit_if.slave  bus
);
    import cpu_pkg::*;

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              dbl_q, dbl_d;
    logic              ff_q, ff_d;

    logic [ADDR_W-1:0] cand;
    logic              cand_legal;
    logic              eret_take;

    // A return only counts inside the handler and when no new exception competes.
    assign eret_take = bus.eret_i && !bus.exc_req_i && (state_q == HANDLER);

    // Candidate PC: saved EPC on return, else branch target, else next sequential.
    always_comb begin
        cand = pc_q + ADDR_W'(INSTR_B);
        if (eret_take) begin
            cand = epc_q;
        end else if (bus.br_valid_i) begin
            cand = bus.br_target_i;
        end
    end

    pc_range_chk #(
        .ADDR_W  (ADDR_W),
        .ADDR_LO (ADDR_LO),
        .ADDR_HI (ADDR_HI),
        .INSTR_B (INSTR_B)
    ) u_range_chk (
        .addr  (cand),
        .legal (cand_legal)
    );

    // Next-state and priority mux; stall holds everything unless exc/eret override.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        dbl_d   = dbl_q;
        ff_d    = 1'b0;
        if (bus.exc_req_i) begin
            pc_d = EXC_VEC;
            if (state_q == HANDLER) begin
                dbl_d = 1'b1;
            end else begin
                epc_d   = bus.exc_pc_i;
                state_d = HANDLER;
            end
        end else if (eret_take || !bus.stall_i) begin
            if (cand_legal) begin
                pc_d = cand;
                if (eret_take) begin
                    state_d = NORMAL;
                end
            end else begin
                // Illegal fetch address behaves like an exception raised by the current PC.
                pc_d = EXC_VEC;
                ff_d = 1'b1;
                if (state_q == HANDLER) begin
                    dbl_d = 1'b1;
                end else begin
                    epc_d   = pc_q;
                    state_d = HANDLER;
                end
            end
        end
    end

    // State registers with asynchronous reset to the boot vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            dbl_q   <= 1'b0;
            ff_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            dbl_q   <= dbl_d;
            ff_q    <= ff_d;
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.epc_o         = epc_q;
    assign bus.in_handler_o  = (state_q == HANDLER);
    assign bus.fetch_fault_o = ff_q;
    assign bus.dbl_fault_o   = dbl_q;
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus a randomized run
// checked against a behavioural model of the PC selection rules.
module tb_pc_unit;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    pc_unit_if #(.ADDR_W(32)) bus ();

    pc_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Behavioural reference model state.
    logic [31:0] m_pc, m_epc;
    logic        m_hdl, m_ff, m_dbl;

    // Driven request values (kept locally so the model never reads the DUT side).
    logic        s_stall, s_br, s_exc, s_eret;
    logic [31:0] s_tgt, s_epc_in;

    function automatic bit legal_addr(input logic [31:0] a);
        return (a >= 32'h3000) && (a <= 32'h6FFF - 3) && (a % 4 == 0);
    endfunction

    task automatic model_reset();
        m_pc = 32'h3000; m_epc = 32'h0; m_hdl = 1'b0; m_ff = 1'b0; m_dbl = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] next;
        m_ff = 1'b0;
        if (s_exc) begin
            if (m_hdl) m_dbl = 1'b1;
            else begin m_epc = s_epc_in; m_hdl = 1'b1; end
            m_pc = 32'h4180;
        end else if (s_eret && m_hdl) begin
            if (legal_addr(m_epc)) begin m_pc = m_epc; m_hdl = 1'b0; end
            else begin m_pc = 32'h4180; m_dbl = 1'b1; m_ff = 1'b1; end
        end else if (!s_stall) begin
            next = s_br ? s_tgt : m_pc + 32'd4;
            if (legal_addr(next)) m_pc = next;
            else begin
                m_ff = 1'b1;
                if (m_hdl) m_dbl = 1'b1;
                else begin m_epc = m_pc; m_hdl = 1'b1; end
                m_pc = 32'h4180;
            end
        end
    endtask

    // Driver: apply one cycle of requests, advance the model at the edge, settle.
    task automatic drive(input logic stall, input logic br, input logic [31:0] tgt,
                         input logic exc, input logic [31:0] epc_in, input logic eret);
        s_stall = stall; s_br = br; s_tgt = tgt; s_exc = exc; s_epc_in = epc_in; s_eret = eret;
        bus.stall_i = stall; bus.br_valid_i = br; bus.br_target_i = tgt;
        bus.exc_req_i = exc; bus.exc_pc_i = epc_in; bus.eret_i = eret;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        n_tests++; if (bus.pc_o !== 32'h3000) begin n_fail++; $display("FAIL reset_pc got %h want 00003000", bus.pc_o); end
        n_tests++; if (bus.epc_o !== 32'h0) begin n_fail++; $display("FAIL reset_epc got %h want 0", bus.epc_o); end
        n_tests++; if ({bus.in_handler_o, bus.fetch_fault_o, bus.dbl_fault_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got %b want 000", {bus.in_handler_o, bus.fetch_fault_o, bus.dbl_fault_o}); end
        rst_n = 1'b1;
        // Run a little, then assert reset between edges and check without any clock edge.
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h3010, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++; if ({bus.pc_o, bus.epc_o, bus.in_handler_o} !== {32'h3000, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL async_reset got pc=%h epc=%h hdl=%b want 00003000 0 0", bus.pc_o, bus.epc_o, bus.in_handler_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_seq_stall();
        logic [31:0] exp_pc;
        exp_pc = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            exp_pc = exp_pc + 32'd4;
            n_tests++; if (bus.pc_o !== exp_pc) begin n_fail++; $display("FAIL seq_%0d got %h want %h", i, bus.pc_o, exp_pc); end
        end
        drive(1, 1, 32'h3400, 0, 0, 0);
        n_tests++; if ({bus.pc_o, bus.fetch_fault_o} !== {32'h300C, 1'b0}) begin
            n_fail++; $display("FAIL stall_drops_branch got pc=%h ff=%b want 0000300c 0", bus.pc_o, bus.fetch_fault_o); end
    endtask

    task automatic test_branch();
        drive(0, 1, 32'h3400, 0, 0, 0);
        n_tests++; if (bus.pc_o !== 32'h3400) begin n_fail++; $display("FAIL branch_taken got %h want 00003400", bus.pc_o); end
        drive(0, 1, 32'h3402, 0, 0, 0);
        n_tests++; if ({bus.pc_o, bus.epc_o, bus.fetch_fault_o, bus.in_handler_o} !== {32'h4180, 32'h3400, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL misaligned_branch got pc=%h epc=%h ff=%b hdl=%b want 00004180 00003400 1 1",
                               bus.pc_o, bus.epc_o, bus.fetch_fault_o, bus.in_handler_o); end
        drive(0, 0, 0, 0, 0, 0);
        n_tests++; if ({bus.pc_o, bus.fetch_fault_o, bus.dbl_fault_o} !== {32'h4184, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL handler_seq got pc=%h ff=%b dbl=%b want 00004184 0 0", bus.pc_o, bus.fetch_fault_o, bus.dbl_fault_o); end
        drive(0, 0, 0, 0, 0, 1);
        n_tests++; if ({bus.pc_o, bus.in_handler_o} !== {32'h3400, 1'b0}) begin
            n_fail++; $display("FAIL eret_after_fault got pc=%h hdl=%b want 00003400 0", bus.pc_o, bus.in_handler_o); end
    endtask

    task automatic test_exception();
        drive(1, 0, 0, 1, 32'h3010, 0);
        n_tests++; if ({bus.pc_o, bus.epc_o, bus.in_handler_o, bus.fetch_fault_o} !== {32'h4180, 32'h3010, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL exc_over_stall got pc=%h epc=%h hdl=%b ff=%b want 00004180 00003010 1 0",
                               bus.pc_o, bus.epc_o, bus.in_handler_o, bus.fetch_fault_o); end
        drive(1, 0, 0, 0, 0, 1);
        n_tests++; if ({bus.pc_o, bus.in_handler_o} !== {32'h3010, 1'b0}) begin
            n_fail++; $display("FAIL eret_over_stall got pc=%h hdl=%b want 00003010 0", bus.pc_o, bus.in_handler_o); end
    endtask

    task automatic test_double_fault();
        drive(0, 0, 0, 1, 32'h3020, 0);
        drive(0, 0, 0, 1, 32'h4184, 0);
        n_tests++; if ({bus.pc_o, bus.epc_o, bus.dbl_fault_o, bus.in_handler_o} !== {32'h4180, 32'h3020, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL double_fault got pc=%h epc=%h dbl=%b hdl=%b want 00004180 00003020 1 1",
                               bus.pc_o, bus.epc_o, bus.dbl_fault_o, bus.in_handler_o); end
        drive(0, 0, 0, 0, 0, 1);
        n_tests++; if ({bus.pc_o, bus.dbl_fault_o, bus.in_handler_o} !== {32'h3020, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL dbl_sticky got pc=%h dbl=%b hdl=%b want 00003020 1 0", bus.pc_o, bus.dbl_fault_o, bus.in_handler_o); end
        do_reset();
        #1;
        n_tests++; if (bus.dbl_fault_o !== 1'b0) begin n_fail++; $display("FAIL dbl_cleared_by_reset got %b want 0", bus.dbl_fault_o); end
    endtask

    task automatic test_boundary();
        drive(0, 1, 32'h6FFC, 0, 0, 0);
        n_tests++; if (bus.pc_o !== 32'h6FFC) begin n_fail++; $display("FAIL top_legal got %h want 00006ffc", bus.pc_o); end
        drive(0, 0, 0, 0, 0, 0);
        n_tests++; if ({bus.pc_o, bus.epc_o, bus.fetch_fault_o, bus.in_handler_o} !== {32'h4180, 32'h6FFC, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL seq_past_top got pc=%h epc=%h ff=%b hdl=%b want 00004180 00006ffc 1 1",
                               bus.pc_o, bus.epc_o, bus.fetch_fault_o, bus.in_handler_o); end
        drive(0, 0, 0, 0, 0, 1);
        n_tests++; if (bus.pc_o !== 32'h6FFC) begin n_fail++; $display("FAIL eret_to_top got %h want 00006ffc", bus.pc_o); end
        drive(0, 1, 32'h3500, 0, 0, 1);
        n_tests++; if ({bus.pc_o, bus.in_handler_o, bus.fetch_fault_o} !== {32'h3500, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL eret_ignored_normal got pc=%h hdl=%b ff=%b want 00003500 0 0", bus.pc_o, bus.in_handler_o, bus.fetch_fault_o); end
        drive(0, 1, 32'h2FFC, 0, 0, 0);
        n_tests++; if ({bus.pc_o, bus.epc_o, bus.fetch_fault_o} !== {32'h4180, 32'h3500, 1'b1}) begin
            n_fail++; $display("FAIL below_low got pc=%h epc=%h ff=%b want 00004180 00003500 1", bus.pc_o, bus.epc_o, bus.fetch_fault_o); end
        drive(0, 1, 32'h7000, 0, 0, 0);
        n_tests++; if ({bus.pc_o, bus.epc_o, bus.dbl_fault_o, bus.fetch_fault_o} !== {32'h4180, 32'h3500, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL illegal_in_handler got pc=%h epc=%h dbl=%b ff=%b want 00004180 00003500 1 1",
                               bus.pc_o, bus.epc_o, bus.dbl_fault_o, bus.fetch_fault_o); end
        do_reset();
    endtask

    task automatic test_random();
        logic [31:0] tgt, epc_in;
        int          kind;
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6)      tgt = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
            else if (kind < 8) tgt = 32'h3000 + $urandom_range(0, 32'h3FFF);
            else               tgt = $urandom_range(0, 32'hFFFF);
            kind = $urandom_range(0, 3);
            epc_in = (kind == 0) ? $urandom_range(0, 32'hFFFF) : 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 4, tgt,
                  $urandom_range(0, 9) == 0, epc_in, $urandom_range(0, 3) == 0);
            n_tests++;
            if ({bus.pc_o, bus.epc_o, bus.in_handler_o, bus.fetch_fault_o, bus.dbl_fault_o} !==
                {m_pc, m_epc, m_hdl, m_ff, m_dbl}) begin
                n_fail++;
                $display("FAIL random_%0d got pc=%h epc=%h hdl=%b ff=%b dbl=%b want pc=%h epc=%h hdl=%b ff=%b dbl=%b",
                         i, bus.pc_o, bus.epc_o, bus.in_handler_o, bus.fetch_fault_o, bus.dbl_fault_o,
                         m_pc, m_epc, m_hdl, m_ff, m_dbl);
            end
            if ($urandom_range(0, 99) == 0) do_reset();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        model_reset();
        test_reset();
        test_seq_stall();
        test_branch();
        test_exception();
        test_double_fault();
        test_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
